// File: rtl/audio_stream_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_stream_buffer
//  Description : Multi-channel audio sample buffer. The host writes whole
//                lines at explicit indices; a playback engine streams
//                interleaved frames over valid/ready, stalling on lines that
//                have not been written yet.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_stream_buffer #(
  parameter  int SAMPLE_W  = 16,
  parameter  int CHANNELS  = 2,
  parameter  int FRAMES    = 512,
  parameter  int LINE_W    = 512,
  localparam int C_FRAME_W = CHANNELS * SAMPLE_W,
  localparam int C_FPL     = LINE_W / C_FRAME_W,
  localparam int C_LINES   = FRAMES / C_FPL,
  localparam int C_LIDX_W  = $clog2(C_LINES),
  localparam int C_CNT_W   = $clog2(C_LINES + 1),
  localparam int C_LEN_W   = $clog2(FRAMES + 1),
  localparam int C_FIDX_W  = $clog2(FRAMES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [LINE_W-1:0]    wr_line,
  input  logic [C_LIDX_W-1:0]  wr_index,
  output logic [C_CNT_W-1:0]   lines_filled,
  input  logic                 start,
  input  logic [C_LEN_W-1:0]   len_frames,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [C_FRAME_W-1:0] out_frame,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_STREAM = 2'd1;
  localparam logic [1:0] c_ST_DONE   = 2'd2;

  // Parameter sanity: a line must hold a whole number of frames
  generate
    if ((LINE_W % C_FRAME_W) != 0) begin : g_bad_line_w
      $error("LINE_W must be a multiple of CHANNELS*SAMPLE_W");
    end
    if ((SAMPLE_W % 8) != 0) begin : g_bad_sample_w
      $error("SAMPLE_W must be a multiple of 8");
    end
  endgenerate

  logic [C_FRAME_W-1:0] r_mem [FRAMES];
  logic [C_LINES-1:0]   r_flags;
  logic [C_CNT_W-1:0]   r_filled;
  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [C_LEN_W-1:0]   r_rd_ptr;
  logic [C_LEN_W-1:0]   r_len;
  logic [C_LEN_W-1:0]   w_len_clamped;
  logic [C_LEN_W-1:0]   w_rd_line;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic [C_FRAME_W-1:0] r_out_frame;
  logic                 w_idx_ok;
  logic                 w_wr_take;
  logic                 w_avail;
  logic                 w_load;
  logic                 w_accept_last;
  logic                 w_busy;
  logic                 w_done;

  // An index range that exactly covers the line count needs no bound check
  generate
    if ((1 << C_LIDX_W) == C_LINES) begin : g_idx_full
      assign w_idx_ok = 1'b1;
    end else begin : g_idx_part
      assign w_idx_ok = ({1'b0, wr_index} < (C_LIDX_W + 1)'(C_LINES));
    end
  endgenerate

  assign w_wr_take     = wr_en && !clear && w_idx_ok;
  assign w_len_clamped = (len_frames > C_LEN_W'(FRAMES)) ? C_LEN_W'(FRAMES) : len_frames;
  assign w_rd_line     = r_rd_ptr / C_LEN_W'(C_FPL);
  assign w_avail       = (r_rd_ptr < r_len) && r_flags[w_rd_line[C_LIDX_W-1:0]];
  assign w_load        = (r_state == c_ST_STREAM) && (!r_out_valid || out_ready);
  assign w_accept_last = r_out_valid && out_ready && r_out_last;

  // Line storage: a host write scatters one line into FPL consecutive frames
  always_ff @(posedge clk) begin
    if (w_wr_take) begin
      for (int k = 0; k < C_FPL; k++) begin
        r_mem[C_FIDX_W'(int'(wr_index) * C_FPL + k)] <= wr_line[C_FRAME_W*k +: C_FRAME_W];
      end
    end
  end

  // Written flags and fill count; clear wins over a same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags  <= '0;
      r_filled <= '0;
    end else if (clear) begin
      r_flags  <= '0;
      r_filled <= '0;
    end else if (w_wr_take) begin
      r_flags[wr_index] <= 1'b1;
      if (!r_flags[wr_index]) begin
        r_filled <= r_filled + C_CNT_W'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: clear aborts any activity back to IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE:   if (start) w_state_nxt = (w_len_clamped == '0) ? c_ST_DONE : c_ST_STREAM;
        c_ST_STREAM: if (w_accept_last) w_state_nxt = c_ST_DONE;
        c_ST_DONE:   w_state_nxt = c_ST_IDLE;
        default:     w_state_nxt = c_ST_IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the current state
  always_comb begin
    w_busy = (r_state == c_ST_STREAM);
    w_done = (r_state == c_ST_DONE);
  end

  // Playback datapath: output register refills whenever empty or consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_len       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_frame <= '0;
    end else if (clear) begin
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if ((r_state == c_ST_IDLE) && start) begin
      r_len    <= w_len_clamped;
      r_rd_ptr <= '0;
    end else if (w_load) begin
      if (w_avail) begin
        r_out_frame <= r_mem[r_rd_ptr[C_FIDX_W-1:0]];
        r_out_valid <= 1'b1;
        r_out_last  <= (r_rd_ptr == (r_len - C_LEN_W'(1)));
        r_rd_ptr    <= r_rd_ptr + C_LEN_W'(1);
      end else begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign lines_filled = r_filled;
  assign out_valid    = r_out_valid;
  assign out_frame    = r_out_frame;
  assign out_last     = r_out_last;
  assign busy         = w_busy;
  assign done         = w_done;

endmodule
`default_nettype wire

// File: tb/tb_audio_stream_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_stream_buffer
//  Description : Directed self-checking bench for audio_stream_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_stream_buffer;

  localparam int FPL = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         wr_en = 1'b0;
  logic [511:0] wr_line = '0;
  logic [4:0]   wr_index = '0;
  logic [5:0]   lines_filled;
  logic         start = 1'b0;
  logic [9:0]   len_frames = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_frame;
  logic         out_last;
  logic         busy;
  logic         done;

  int n_pass = 0;
  int n_total = 0;
  int m_beats, m_data_err, m_last_err, m_hold_err, m_done, m_first_valid, m_valid_cnt, m_len;

  always #5 clk = ~clk;

  audio_stream_buffer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .wr_line(wr_line),
    .wr_index(wr_index), .lines_filled(lines_filled), .start(start),
    .len_frames(len_frames), .out_valid(out_valid), .out_ready(out_ready),
    .out_frame(out_frame), .out_last(out_last), .busy(busy), .done(done)
  );

  function automatic logic [31:0] exp_frame(input int k);
    return {16'(2 * k + 1), 16'(2 * k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0; wr_en = 1'b0; start = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_line(input int line);
    for (int k = 0; k < FPL; k++) wr_line[32*k +: 32] = exp_frame(line * FPL + k);
    wr_index = 5'(line);
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic write_all();
    for (int l = 0; l < 32; l++) write_line(l);
  endtask

  task automatic start_stream(input int len);
    len_frames = 10'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Collects stream statistics over a bounded number of cycles
  task automatic monitor(input int cycles, input bit rnd);
    logic        prev_stall;
    logic [31:0] prev_frame;
    m_beats = 0; m_data_err = 0; m_last_err = 0; m_hold_err = 0;
    m_done = 0; m_first_valid = -1; m_valid_cnt = 0;
    prev_stall = 1'b0; prev_frame = '0;
    for (int c = 1; c <= cycles; c++) begin
      tick();
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && (!out_valid || out_frame !== prev_frame)) m_hold_err++;
      if (out_valid) m_valid_cnt++;
      if (out_valid && m_first_valid < 0) m_first_valid = c;
      if (done) m_done++;
      if (out_valid && out_ready) begin
        if (out_frame !== exp_frame(m_beats)) m_data_err++;
        if (out_last !== (m_beats == m_len - 1)) m_last_err++;
        m_beats++;
      end
      prev_stall = out_valid && !out_ready;
      prev_frame = out_frame;
    end
  endtask

  task automatic test_reset();
    #1;
    n_total++; if ({out_valid, out_last, busy, done, lines_filled, out_frame} !== '0)
      $display("FAIL reset_outputs: got v=%b l=%b b=%b d=%b f=%0d fr=%h want all 0",
               out_valid, out_last, busy, done, lines_filled, out_frame); else n_pass++;
    do_reset();
    n_total++; if (lines_filled !== 6'd0) $display("FAIL reset_fill: got %0d want 0", lines_filled); else n_pass++;
  endtask

  task automatic test_full_stream();
    do_reset();
    write_all();
    n_total++; if (lines_filled !== 6'd32) $display("FAIL fill_all: got %0d want 32", lines_filled); else n_pass++;
    m_len = 512;
    start_stream(512);
    n_total++; if (busy !== 1'b1) $display("FAIL full_busy: got %b want 1", busy); else n_pass++;
    monitor(530, 1'b0);
    n_total++; if (m_first_valid != 1) $display("FAIL full_latency: got %0d want 1", m_first_valid); else n_pass++;
    n_total++; if (m_beats != 512) $display("FAIL full_beats: got %0d want 512", m_beats); else n_pass++;
    n_total++; if (m_data_err != 0) $display("FAIL full_data: got %0d errors want 0", m_data_err); else n_pass++;
    n_total++; if (m_last_err != 0) $display("FAIL full_last: got %0d errors want 0", m_last_err); else n_pass++;
    n_total++; if (m_done != 1) $display("FAIL full_done: got %0d pulses want 1", m_done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL full_idle: got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_partial_stall();
    do_reset();
    write_line(0);
    write_line(1);
    m_len = 64;
    start_stream(64);
    monitor(50, 1'b0);
    n_total++; if (m_beats != 32) $display("FAIL stall_beats: got %0d want 32", m_beats); else n_pass++;
    n_total++; if (m_data_err != 0) $display("FAIL stall_data: got %0d errors want 0", m_data_err); else n_pass++;
    n_total++; if ({out_valid, busy} !== 2'b01) $display("FAIL stall_state: got v=%b b=%b want v=0 b=1", out_valid, busy); else n_pass++;
    write_line(2);
    n_total++; if (out_valid !== 1'b0) $display("FAIL resume_early: got %b want 0", out_valid); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b1 || out_frame !== exp_frame(32))
      $display("FAIL resume_frame: got v=%b %h want v=1 %h", out_valid, out_frame, exp_frame(32)); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    write_all();
    m_len = 100;
    start_stream(100);
    monitor(400, 1'b1);
    out_ready = 1'b1;
    n_total++; if (m_beats != 100) $display("FAIL bp_beats: got %0d want 100", m_beats); else n_pass++;
    n_total++; if (m_data_err != 0) $display("FAIL bp_data: got %0d errors want 0", m_data_err); else n_pass++;
    n_total++; if (m_hold_err != 0) $display("FAIL bp_hold: got %0d errors want 0", m_hold_err); else n_pass++;
    n_total++; if (m_last_err != 0) $display("FAIL bp_last: got %0d errors want 0", m_last_err); else n_pass++;
    n_total++; if (m_done != 1) $display("FAIL bp_done: got %0d pulses want 1", m_done); else n_pass++;
  endtask

  task automatic test_zero_len();
    start_stream(0);
    n_total++; if ({done, out_valid} !== 2'b10) $display("FAIL zero_done: got d=%b v=%b want d=1 v=0", done, out_valid); else n_pass++;
    tick();
    n_total++; if ({done, busy} !== 2'b00) $display("FAIL zero_after: got d=%b b=%b want 0 0", done, busy); else n_pass++;
    monitor(5, 1'b0);
    n_total++; if (m_valid_cnt != 0 || m_done != 0) $display("FAIL zero_quiet: got valid=%0d done=%0d want 0 0", m_valid_cnt, m_done); else n_pass++;
  endtask

  task automatic test_clamp();
    m_len = 512;
    start_stream(600);
    monitor(530, 1'b0);
    n_total++; if (m_beats != 512) $display("FAIL clamp_beats: got %0d want 512", m_beats); else n_pass++;
    n_total++; if (m_last_err != 0) $display("FAIL clamp_last: got %0d errors want 0", m_last_err); else n_pass++;
    n_total++; if (m_done != 1) $display("FAIL clamp_done: got %0d pulses want 1", m_done); else n_pass++;
  endtask

  task automatic test_clear_midstream();
    m_len = 512;
    start_stream(512);
    monitor(10, 1'b0);
    clear = 1'b1; wr_en = 1'b1; wr_index = 5'd3; wr_line = '0;
    tick();
    clear = 1'b0; wr_en = 1'b0;
    n_total++; if ({out_valid, busy, lines_filled} !== 8'd0)
      $display("FAIL clear_state: got v=%b b=%b f=%0d want 0 0 0", out_valid, busy, lines_filled); else n_pass++;
    monitor(20, 1'b0);
    n_total++; if (m_done != 0 || m_valid_cnt != 0) $display("FAIL clear_quiet: got done=%0d valid=%0d want 0 0", m_done, m_valid_cnt); else n_pass++;
  endtask

  task automatic test_rewrite();
    write_line(5);
    n_total++; if (lines_filled !== 6'd1) $display("FAIL rewrite_first: got %0d want 1", lines_filled); else n_pass++;
    write_line(5);
    n_total++; if (lines_filled !== 6'd1) $display("FAIL rewrite_same: got %0d want 1", lines_filled); else n_pass++;
    write_line(6);
    n_total++; if (lines_filled !== 6'd2) $display("FAIL rewrite_other: got %0d want 2", lines_filled); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    write_line(0);
    start_stream(16);
    tick(); tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", out_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if ({out_valid, out_last, busy, done, lines_filled, out_frame} !== '0)
      $display("FAIL rst_mid: got v=%b l=%b b=%b d=%b f=%0d fr=%h want all 0",
               out_valid, out_last, busy, done, lines_filled, out_frame); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_partial_stall();
    test_backpressure();
    test_zero_len();
    test_clamp();
    test_clear_midstream();
    test_rewrite();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
